// File: rtl/led_share_arbiter.sv
// led_share_arbiter: time-division round-robin sharing of 6 active-low LEDs among 3 requesters.
// Optional feature macro: LED_PREEMPT_EN (requester 0 preempts the others and wins every IDLE arbitration).
module led_share_arbiter #(
   parameter int TICK_DIV    = 13500000,
   parameter int SLICE_TICKS = 4,
   parameter int GAP_CYCLES  = 2
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [2:0] req_i,
   input  logic [5:0] pat0_i,
   input  logic [5:0] pat1_i,
   input  logic [5:0] pat2_i,
   output logic [2:0] grant_o,
   output logic       tick_o,
   output logic [5:0] led_o
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = $clog2(SLICE_TICKS + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, OWN, GAP} state_e;
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;
   logic [SW-1:0] slice_q, slice_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [1:0]    last_q, last_d;
   logic [2:0]    grant_q, grant_d;
   logic [5:0]    led_q, led_d;
   logic [1:0]    cand1, cand2, sel;
   logic [5:0]    cur_pat;
   logic          expire, others, own_req, preempt, gap_last;

   // prescaler wraps at TICK_DIV-1; the tick pulse is the registered wrap
   always_comb begin
      tick_d = cnt_q == CW'(TICK_DIV - 1);
      cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
   end

   // round-robin pick starting after the last owner; last_q doubles as the current owner index
   always_comb begin
      cand1   = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
      cand2   = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;
      sel     = req_i[cand1] ? cand1 : req_i[cand2] ? cand2 : last_q;
`ifdef LED_PREEMPT_EN
      sel     = req_i[0] ? 2'd0 : sel;
      preempt = req_i[0] && !grant_q[0];
`else
      preempt = 1'b0;
`endif
      cur_pat  = (last_q == 2'd0) ? pat0_i : (last_q == 2'd1) ? pat1_i : pat2_i;
      own_req  = |(req_i & grant_q);
      others   = |(req_i & ~grant_q);
      expire   = tick_q && (slice_q == SW'(SLICE_TICKS - 1));
      gap_last = gap_q == GW'(GAP_CYCLES - 1);
   end

   // state register plus all registered outputs and counters
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tick_q  <= 1'b0;
         slice_q <= '0;
         gap_q   <= '0;
         last_q  <= 2'd2;
         grant_q <= '0;
         led_q   <= 6'h3F;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tick_q  <= tick_d;
         slice_q <= slice_d;
         gap_q   <= gap_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         led_q   <= led_d;
      end
   end

   // next state: owner drop, preemption or contended slice expiry all leave OWN through GAP
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = |req_i ? OWN : IDLE;
         OWN:     state_d = (!own_req || preempt || (expire && others)) ? GAP : OWN;
         GAP:     state_d = gap_last ? IDLE : GAP;
         default: state_d = IDLE;
      endcase
   end

   // outputs: LEDs show the owner pattern only while ownership continues, dark on entry and exit
   always_comb begin
      grant_d = '0;
      led_d   = 6'h3F;
      last_d  = last_q;
      slice_d = slice_q;
      gap_d   = (state_q == GAP && state_d == GAP) ? gap_q + 1'b1 : '0;
      if (state_q == IDLE && state_d == OWN) begin
         grant_d = 3'b001 << sel;
         last_d  = sel;
         slice_d = '0;
      end else if (state_q == OWN && state_d == OWN) begin
         grant_d = grant_q;
         led_d   = ~cur_pat;
         slice_d = expire ? '0 : slice_q + SW'(tick_q);
      end
   end

   assign grant_o = grant_q;
   assign tick_o  = tick_q;
   assign led_o   = led_q;
endmodule

// File: tb/tb_led_share_arbiter.sv
// tb_led_share_arbiter: table vectors, corner sequences and random traffic against a cycle model.
module tb_led_share_arbiter;
   localparam int TD = 4;
   localparam int SL = 2;
   localparam int GP = 2;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic [2:0] req_i = '0;
   logic [5:0] pat0_i = '0, pat1_i = '0, pat2_i = '0;
   logic [2:0] grant_o;
   logic       tick_o;
   logic [5:0] led_o;

   led_share_arbiter #(.TICK_DIV(TD), .SLICE_TICKS(SL), .GAP_CYCLES(GP)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i),
      .pat0_i(pat0_i), .pat1_i(pat1_i), .pat2_i(pat2_i),
      .grant_o(grant_o), .tick_o(tick_o), .led_o(led_o)
   );

   always #5 clk_i = ~clk_i;

   int n_vec = 0;
   int n_bad = 0;

   // model: owner index (-1 none), dark cycles left, ticks in slice, edges since reset
   int         m_owner, m_last, m_ticks, m_dark, m_cyc;
   logic [5:0] m_led;
   logic       m_tick;

   typedef struct {
      logic [2:0] req;
      logic [5:0] p1;
      logic [2:0] g;
      logic [5:0] led;
      logic       tk;
   } vec_t;
   vec_t tbl[8];

   task automatic chk(input string n, input logic [5:0] act, input logic [5:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_owner = -1; m_last = 2; m_ticks = 0; m_dark = 0; m_cyc = 0;
      m_led = 6'h3F; m_tick = 1'b0;
   endtask

   task automatic m_step(input logic [2:0] r, input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
      bit tk_now = (m_cyc > 0) && (m_cyc % TD == 0);
      logic [5:0] pats [3];
      pats = '{a, b, c};
      m_led = 6'h3F;
      if (m_owner < 0) begin
         if (m_dark > 0) m_dark--;
         else if (r != 0) begin
            int pick = -1;
            for (int k = 1; k <= 3; k++) if (pick < 0 && r[(m_last + k) % 3]) pick = (m_last + k) % 3;
`ifdef LED_PREEMPT_EN
            if (r[0]) pick = 0;
`endif
            m_owner = pick; m_last = pick; m_ticks = 0;
         end
      end else begin
         int t = m_ticks + (tk_now ? 1 : 0);
         bit oth = (r & ~(3'b001 << m_owner)) != 0;
         bit pre = 1'b0;
`ifdef LED_PREEMPT_EN
         pre = (m_owner != 0) && r[0];
`endif
         if (!r[m_owner] || (t == SL && oth) || pre) begin
            m_owner = -1; m_dark = GP;
         end else begin
            m_led = ~pats[m_owner];
            m_ticks = (t == SL) ? 0 : t;
         end
      end
      m_cyc++;
      m_tick = (m_cyc % TD == 0);
   endtask

   task automatic cycle(input logic [2:0] r, input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
      logic [2:0] mg;
      req_i = r; pat0_i = a; pat1_i = b; pat2_i = c;
      m_step(r, a, b, c);
      @(posedge clk_i); #1;
      mg = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
      chk("grant", 6'(grant_o), 6'(mg));
      chk("led", led_o, m_led);
      chk("tick", 6'(tick_o), 6'(m_tick));
   endtask

   task automatic do_reset();
      rst_ni = 1'b0; req_i = '0;
      #1;
      chk("rst_grant", 6'(grant_o), 6'h00);
      chk("rst_led", led_o, 6'h3F);
      chk("rst_tick", 6'(tick_o), 6'h00);
      m_reset();
      #1 rst_ni = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      int rises, len, gapc, lens_ok, gaps_ok;
      logic [2:0] seq[$];
      logic [2:0] prev, r;
      logic [5:0] a, b, c;
      logic [2:0] exp_pre[8];
      tbl[0] = '{3'b000, 6'h15, 3'b000, 6'h3F, 1'b0};
      tbl[1] = '{3'b010, 6'h15, 3'b010, 6'h3F, 1'b0};
      tbl[2] = '{3'b010, 6'h15, 3'b010, 6'h2A, 1'b0};
      tbl[3] = '{3'b010, 6'h15, 3'b010, 6'h2A, 1'b1};
      tbl[4] = '{3'b010, 6'h15, 3'b010, 6'h2A, 1'b0};
      tbl[5] = '{3'b010, 6'h00, 3'b010, 6'h3F, 1'b0};
      tbl[6] = '{3'b010, 6'h3F, 3'b010, 6'h00, 1'b0};
      tbl[7] = '{3'b010, 6'h01, 3'b010, 6'h3E, 1'b1};
      #12;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         cycle(tbl[i].req, 6'h00, tbl[i].p1, 6'h00);
         chk($sformatf("tbl%0d_grant", i), 6'(grant_o), 6'(tbl[i].g));
         chk($sformatf("tbl%0d_led", i), led_o, tbl[i].led);
         chk($sformatf("tbl%0d_tick", i), 6'(tick_o), 6'(tbl[i].tk));
      end
      len = 0;
      for (int i = 0; i < 40; i++) begin
         cycle(3'b010, 6'h00, 6'h15, 6'h00);
         if (grant_o !== 3'b010 || led_o !== 6'h2A) len++;
      end
      chk("hold_glitches", 6'(len), 6'h00);
      chk("async_pre_grant", 6'(grant_o), 6'h02);
      do_reset();
      seq.delete(); prev = '0; rises = 0; len = 0; gapc = 0; lens_ok = 1; gaps_ok = 1;
      for (int i = 0; i < 80 && rises < 4; i++) begin
         cycle(3'b111, 6'h01, 6'h02, 6'h04);
         if (grant_o != 0 && prev == 0) begin
            seq.push_back(grant_o); rises++;
            if (rises > 1 && gapc != GP + 1) gaps_ok = 0;
            len = 0;
         end
         if (grant_o == 0 && prev != 0) begin
            if (len < (SL - 1) * TD + 1 || len > SL * TD) lens_ok = 0;
            gapc = 0;
         end
         if (grant_o != 0) len++; else gapc++;
         prev = grant_o;
      end
      chk("rot_count", 6'(rises), 6'd4);
      if (seq.size() == 4) begin
         chk("rot0", 6'(seq[0]), 6'h01);
         chk("rot1", 6'(seq[1]), 6'h02);
         chk("rot2", 6'(seq[2]), 6'h04);
         chk("rot3", 6'(seq[3]), 6'h01);
      end
      chk("rot_lengths", 6'(lens_ok), 6'h01);
      chk("rot_gaps", 6'(gaps_ok), 6'h01);
      do_reset();
      cycle(3'b111, 6'h00, 6'h00, 6'h00);
      chk("er_grant0", 6'(grant_o), 6'h01);
      cycle(3'b111, 6'h00, 6'h00, 6'h00);
      cycle(3'b110, 6'h00, 6'h00, 6'h00);
      chk("er_drop", 6'(grant_o), 6'h00);
      chk("er_drop_led", led_o, 6'h3F);
      cycle(3'b110, 6'h00, 6'h00, 6'h00);
      chk("er_gap2", 6'(grant_o), 6'h00);
      cycle(3'b110, 6'h00, 6'h00, 6'h00);
      chk("er_idle", 6'(grant_o), 6'h00);
      cycle(3'b110, 6'h00, 6'h00, 6'h00);
      chk("er_next", 6'(grant_o), 6'h02);
      do_reset();
      cycle(3'b100, 6'h00, 6'h00, 6'h15);
      chk("pt_grant", 6'(grant_o), 6'h04);
      cycle(3'b100, 6'h00, 6'h00, 6'h15);
      chk("pt_first", led_o, 6'h2A);
      cycle(3'b100, 6'h00, 6'h00, 6'h00);
      chk("pt_00", led_o, 6'h3F);
      cycle(3'b100, 6'h00, 6'h00, 6'h3F);
      chk("pt_3F", led_o, 6'h00);
      cycle(3'b100, 6'h00, 6'h00, 6'h01);
      chk("pt_01", led_o, 6'h3E);
      do_reset();
      cycle(3'b010, 6'h00, 6'h00, 6'h00);
      chk("pre_own1", 6'(grant_o), 6'h02);
`ifdef LED_PREEMPT_EN
      exp_pre = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`else
      exp_pre = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000};
`endif
      for (int i = 0; i < 8; i++) begin
         cycle(3'b011, 6'h00, 6'h00, 6'h00);
         chk($sformatf("pre%0d", i), 6'(grant_o), 6'(exp_pre[i]));
      end
      do_reset();
      r = 3'b111; a = 6'h11; b = 6'h22; c = 6'h33;
      for (int i = 0; i < 900; i++) begin
         if (i == 450) do_reset();
         if ($urandom_range(7) == 0) r = 3'($urandom);
         if ($urandom_range(3) == 0) a = 6'($urandom);
         if ($urandom_range(3) == 0) b = 6'($urandom);
         if ($urandom_range(3) == 0) c = 6'($urandom);
         cycle(r, a, b, c);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/led_share_arbiter.md
Name: led_share_arbiter

Overview:
- Time-division arbiter sharing the board's 6 active-low LEDs between three pattern requesters, e.g. a counter display, a status display and a debug display.
- Free-running prescaler produces a slow tick; each granted requester owns the LEDs for a fixed number of ticks, rotating round-robin.
- A short dark gap separates owners.
- Sits between pattern-generating blocks and the top-level `led` pins.

Parameters:
- TICK_DIV, 13500000, clk cycles per tick (≥2); 0.5 s at 27 MHz.
- SLICE_TICKS, 4, ticks per ownership slice (≥1).
- GAP_CYCLES, 2, clk cycles of LEDs-off between owners (≥1).

Ports:
- clk  in  1  system clock (27 MHz)
- rst_n  in  1  asynchronous active-low reset
- req  in  3  request per requester; level, held while wanting the LEDs
- pat0  in  6  requester 0 pattern, active-high (1 = LED lit)
- pat1  in  6  requester 1 pattern, active-high
- pat2  in  6  requester 2 pattern, active-high
- grant  out  3  one-hot current owner, 0 when none
- tick  out  1  one-cycle pulse every TICK_DIV cycles
- led  out  6  LED pins, active-low (1 = off)

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: led=6'h3F, grant=0, tick=0.
  - Internal: prescaler=0, slice count=0, state=IDLE, last_owner=2, so requester 0 is first in priority.
- Prescaler:
  - Width $clog2(TICK_DIV); counts 0..TICK_DIV-1 and wraps.
  - tick registered high for exactly the cycle after count==TICK_DIV-1.
  - Free-runs regardless of state; never cleared except by reset.
- State IDLE:
  - grant=0, led=6'h3F.
  - If any req bit is set, select the first set bit searching last_owner+1, +2, +3 (mod 3).
  - Next edge: state=OWN, grant=onehot(sel), last_owner=sel, slice count=0.
  - req→grant latency is 1 cycle.
- State OWN:
  - Every cycle led <= ~pat[owner], registered; first owner pattern appears 1 cycle after grant rises.
  - Pattern changes propagate with 1-cycle latency.
  - Slice count (width $clog2(SLICE_TICKS+1)) increments on each tick pulse.
  - Owner req low → next edge: state=GAP, grant=0, led=6'h3F. This has priority over all other OWN exits.
  - Slice count reaches SLICE_TICKS while another req bit is set → GAP.
  - Slice count reaches SLICE_TICKS with no other req set → stay OWN, slice count=0, no gap, no grant glitch.
  - Ownership length under contention: between (SLICE_TICKS-1)*TICK_DIV+1 and SLICE_TICKS*TICK_DIV cycles, depending on tick phase.
- State GAP:
  - grant=0, led=6'h3F for exactly GAP_CYCLES cycles, then IDLE.
  - req is ignored during GAP.
  - IDLE arbitrates in its first cycle, so the next grant arrives GAP_CYCLES+1 cycles after the previous grant fell.
- Simultaneous events: owner drop and slice expiry in the same cycle → GAP (single transition).
- Invariants:
  - grant is always 0 or one-hot.
  - led is 6'h3F whenever grant==0, except the single cycle after grant falls, when led is already off.
- Reset mid-operation:
  - Immediate async clear to reset values.
  - After rst_n deasserts, arbitration restarts from requester 0 priority.

Optional Feature:
- LED_PREEMPT_EN defined:
  - Requester 0 is high priority. In OWN with owner≠0 and req[0]=1, the next edge goes to GAP regardless of slice count.
  - IDLE always selects requester 0 when req[0]=1.
  - Requester 0 is never preempted; it still yields at slice expiry only when others are pending.
- Not defined: pure round-robin as above; req[0] has no special treatment.

Test Plan:
- Params TICK_DIV=4, SLICE_TICKS=2, GAP_CYCLES=2 unless noted.
- Reset/tick: hold rst_n=0, release, req=0 → led=6'h3F, grant=0; tick pulses one cycle wide every 4 cycles, first pulse 4 cycles after release. Assert rst_n=0 while grant=3'b010 → grant=0 and led=6'h3F immediately, without waiting for a clock edge.
- Single requester: req=3'b010, pat1=6'h15 → grant=3'b010 one cycle later, led=6'h2A the cycle after. Hold for 40 cycles: grant and led never change, no gap.
- Full rotation: req=3'b111 from reset → grant sequence 001, 010, 100, 001. Each grant lasts 5–8 cycles, separated by exactly 2 cycles of grant=0, led=6'h3F.
- Early release: owner 0 drops req[0] in the 2nd cycle of ownership, req=3'b110 → grant=0 next edge; 2 gap cycles; then 1 IDLE cycle; then grant=3'b010.
- Pattern tracking: while owner 2, step pat2 through 6'h00, 6'h3F, 6'h01 → led reads 6'h3F, 6'h00, 6'h3E, each one cycle after the input change.
- Preempt (LED_PREEMPT_EN): owner 1 at slice count 0, raise req[0] → grant=0 next edge, 2-cycle gap, then grant=3'b001. Without the macro, owner 1 keeps the full slice.
